// File: rtl/spi_mult_pkg.sv
// Shared types and constants for the SPI multiply master.
// Operand width, frame width, FSM states and the SPI mode-0 idle level.
package spi_mult_pkg;

  localparam int OP_W    = 4;
  localparam int FRAME_W = 2 * OP_W;

  localparam logic SCLK_IDLE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT,
    RECV,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_mult_master_if.sv
// Host-side start/done bundle of the SPI multiply master.
// master drives a request, slave is the SPI controller itself.
interface spi_mult_master_if;
  import spi_mult_pkg::*;

  logic               start;
  logic [OP_W-1:0]    a;
  logic [OP_W-1:0]    b;
  logic               busy;
  logic               done;
  logic [FRAME_W-1:0] product;
  logic               err;

  modport master (
    output start, a, b,
    input  busy, done, product, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, err
  );

endinterface

// File: rtl/spi_mult_master_sclk_gen.sv
// SCLK generator: half-period counter with enable and toggle gate.
// Ticks mark the clk cycle before SCLK rises/falls and the last high cycle.
module spi_mult_master_sclk_gen
  import spi_mult_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic tog_i,
  output logic sclk_o,
  output logic half_tick_o,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic sample_tick_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          half;

  always_comb begin
    half   = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q + CW'(1);
    sclk_d = sclk_q;
    if (!en_i || half) cnt_d = '0;
    if (!en_i) sclk_d = SCLK_IDLE;
    else if (half && tog_i) sclk_d = ~sclk_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= SCLK_IDLE;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o        = sclk_q;
  assign half_tick_o   = half;
  assign rise_tick_o   = half && tog_i && !sclk_q;
  assign fall_tick_o   = half && tog_i && sclk_q;
  assign sample_tick_o = half && sclk_q;

endmodule

// File: rtl/spi_mult_master.sv
// SPI master for one multiply transaction: send {b,a}, idle, receive product.
// SPI_MULT_CHECK_EN adds a local a*b compare driving err.
module spi_mult_master
  import spi_mult_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int WAIT_SCLKS = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_mult_master_if.slave host,
  output logic             SCLK,
  output logic             CS,
  output logic             MOSI,
  input  logic             MISO
);

  localparam logic [15:0] FRAME_P = 16'(FRAME_W);
  localparam logic [15:0] WAIT_P  = 16'(WAIT_SCLKS);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] prod_q, prod_d;
  logic [15:0]        per_q, per_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               done_q, done_d;
  logic               accept, en, tog;
  logic               half_tick, rise_tick;
  logic               fall_tick, sample_tick;

  assign accept = host.start && (state_q == IDLE);
  assign en     = (state_q != IDLE);

  // The last low half of RECV must not rise: HOLD follows with SCLK low.
  always_comb begin
    tog = 1'b0;
    unique case (state_q)
      SETUP, SEND, WAIT: tog = 1'b1;
      RECV:              tog = (per_q != FRAME_P);
      default:           tog = 1'b0;
    endcase
  end

  spi_mult_master_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en),
    .tog_i        (tog),
    .sclk_o       (SCLK),
    .half_tick_o  (half_tick),
    .rise_tick_o  (rise_tick),
    .fall_tick_o  (fall_tick),
    .sample_tick_o(sample_tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    prod_d  = prod_q;
    per_d   = per_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        if (accept) begin
          state_d = SETUP;
          tx_d    = {host.b, host.a};
          rx_d    = '0;
          per_d   = '0;
          mosi_d  = host.b[OP_W-1];
        end
      end
      SETUP: if (rise_tick) state_d = SEND;
      SEND: begin
        if (fall_tick) begin
          per_d  = per_q + 16'd1;
          tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
          mosi_d = tx_q[FRAME_W-2];
        end
        if (rise_tick && per_q == FRAME_P) begin
          per_d   = '0;
          state_d = (WAIT_SCLKS == 0) ? RECV : WAIT;
        end
      end
      WAIT: begin
        if (fall_tick) per_d = per_q + 16'd1;
        if (rise_tick && per_q == WAIT_P) begin
          per_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (sample_tick) begin
          rx_d  = {rx_q[FRAME_W-2:0], MISO};
          per_d = per_q + 16'd1;
        end
        if (half_tick && per_q == FRAME_P) state_d = HOLD;
      end
      HOLD: begin
        if (half_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          prod_d  = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
    cs_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      prod_q  <= '0;
      per_q   <= '0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      prod_q  <= prod_d;
      per_q   <= per_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  assign CS           = cs_q;
  assign MOSI         = mosi_q;
  assign host.busy    = en;
  assign host.done    = done_q;
  assign host.product = prod_q;

`ifdef SPI_MULT_CHECK_EN
  logic [OP_W-1:0]    opa_q, opb_q;
  logic               err_q, err_d;
  logic [FRAME_W-1:0] chk_prod;

  assign chk_prod = {{OP_W{1'b0}}, opa_q} * {{OP_W{1'b0}}, opb_q};

  always_comb begin
    err_d = err_q;
    if (state_q == HOLD && half_tick) err_d = (rx_q != chk_prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        opa_q <= host.a;
        opb_q <= host.b;
      end
      err_q <= err_d;
    end
  end

  assign host.err = err_q;
`else
  assign host.err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mult_master.sv
// Directed bench for spi_mult_master with a behavioural SPI multiplier peripheral.
// The err checks follow SPI_MULT_CHECK_EN as the design does.
module tb_spi_mult_master;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 153;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic SCLK, CS, MOSI;
  logic MISO  = 1'b0;

  spi_mult_master_if host();

  spi_mult_master #(
    .CLK_DIV   (4),
    .WAIT_SCLKS(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .host (host),
    .SCLK (SCLK),
    .CS   (CS),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  logic [7:0]  resp = 8'h00;
  int          rises = 0;
  logic [17:0] mosi_sh = '0;

  // Peripheral: counts SCLK rises in a frame, records MOSI,
  // and presents product bit 7..0 during the high halves of rises 11..18.
  always @(posedge SCLK or negedge CS) begin
    if (SCLK === 1'b1) begin
      rises   = rises + 1;
      mosi_sh = {mosi_sh[16:0], MOSI};
      if (rises >= 11 && rises <= 18) MISO = resp[3'(18 - rises)];
      else MISO = 1'b0;
    end else begin
      rises   = 0;
      mosi_sh = '0;
      MISO    = 1'b0;
    end
  end

  task automatic do_txn(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [7:0] tr, output int lat,
                        output int cs_bad, output int hi_bad,
                        output logic [7:0] p);
    int hl;
    hl = 0; cs_bad = 0; hi_bad = 0;
    host.a = ta; host.b = tb_v; resp = tr;
    host.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host.start = 1'b0;
    lat = 1;
    while (host.done !== 1'b1 && lat < 1000) begin
      if (CS !== 1'b0) cs_bad++;
      if (SCLK === 1'b1) hl++;
      else begin
        if (hl != 0 && hl != CLK_DIV) hi_bad++;
        hl = 0;
      end
      @(negedge clk);
      lat++;
    end
    p = host.product;
  endtask

  task automatic test_reset();
    host.start = 1'b0; host.a = '0; host.b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (CS !== 1'b1) begin bad++; $display("FAIL rst_cs got %b want 1", CS); end
    vec++; if (SCLK !== 1'b0) begin bad++; $display("FAIL rst_sclk got %b want 0", SCLK); end
    vec++; if (MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi got %b want 0", MOSI); end
    vec++; if (host.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", host.busy); end
    vec++; if (host.done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", host.done); end
    vec++; if (host.product !== 8'h00) begin bad++; $display("FAIL rst_prod got %h want 00", host.product); end
    vec++; if (host.err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", host.err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, csb, hib;
    logic [7:0] p;
    do_txn(4'h3, 4'h5, 8'h0F, lat, csb, hib, p);
    vec++; if (lat !== LAT) begin bad++; $display("FAIL basic_lat got %0d want %0d", lat, LAT); end
    vec++; if (p !== 8'h0F) begin bad++; $display("FAIL basic_prod got %h want 0f", p); end
    vec++; if (mosi_sh !== {8'h53, 10'h0}) begin bad++; $display("FAIL basic_mosi got %h want %h", mosi_sh, {8'h53, 10'h0}); end
    vec++; if (rises !== 18) begin bad++; $display("FAIL basic_rises got %0d want 18", rises); end
    vec++; if (csb !== 0) begin bad++; $display("FAIL basic_cs_low got %0d want 0", csb); end
    vec++; if (hib !== 0) begin bad++; $display("FAIL basic_high_len got %0d want 0", hib); end
    vec++; if (host.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got %b want 0", host.busy); end
    vec++; if (CS !== 1'b1) begin bad++; $display("FAIL basic_cs_at_done got %b want 1", CS); end
    @(negedge clk);
    vec++; if (host.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got %b want 0", host.done); end
    vec++; if (host.product !== 8'h0F) begin bad++; $display("FAIL basic_prod_hold got %h want 0f", host.product); end
  endtask

  task automatic test_mid_reset();
    int nd;
    host.a = 4'h3; host.b = 4'h5; resp = 8'h0F;
    host.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host.start = 1'b0;
    repeat (30) @(negedge clk);
    vec++; if (CS !== 1'b0) begin bad++; $display("FAIL mid_cs_before got %b want 0", CS); end
    reset = 1'b1;
    @(negedge clk);
    vec++; if (CS !== 1'b1) begin bad++; $display("FAIL mid_cs got %b want 1", CS); end
    vec++; if (SCLK !== 1'b0) begin bad++; $display("FAIL mid_sclk got %b want 0", SCLK); end
    vec++; if (host.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", host.busy); end
    vec++; if (host.product !== 8'h00) begin bad++; $display("FAIL mid_prod got %h want 00", host.product); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (200) begin
      @(negedge clk);
      if (host.done === 1'b1) nd++;
    end
    vec++; if (nd !== 0) begin bad++; $display("FAIL mid_no_done got %0d want 0", nd); end
    vec++; if (host.product !== 8'h00) begin bad++; $display("FAIL mid_prod_after got %h want 00", host.product); end
  endtask

  task automatic test_max();
    int lat, csb, hib;
    logic [7:0] p;
    do_txn(4'hF, 4'hF, 8'hE1, lat, csb, hib, p);
    vec++; if (p !== 8'hE1) begin bad++; $display("FAIL max_prod got %h want e1", p); end
    vec++; if (mosi_sh !== {8'hFF, 10'h0}) begin bad++; $display("FAIL max_mosi got %h want %h", mosi_sh, {8'hFF, 10'h0}); end
    vec++; if (rises !== 18) begin bad++; $display("FAIL max_rises got %0d want 18", rises); end
    vec++; if (lat !== LAT) begin bad++; $display("FAIL max_lat got %0d want %0d", lat, LAT); end
    vec++; if (csb !== 0 || hib !== 0) begin bad++; $display("FAIL max_phases got %0d/%0d want 0/0", csb, hib); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int n, lat, csb, hib;
    logic [7:0] p;
    host.a = 4'h3; host.b = 4'h5; resp = 8'h0F;
    host.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host.start = 1'b0;
    repeat (20) @(negedge clk);
    vec++; if (host.busy !== 1'b1) begin bad++; $display("FAIL ign_busy got %b want 1", host.busy); end
    host.a = 4'h1; host.b = 4'h1;
    host.start = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    n = 0;
    while (host.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vec++; if (n !== LAT - 22) begin bad++; $display("FAIL ign_lat got %0d want %0d", n, LAT - 22); end
    vec++; if (host.product !== 8'h0F) begin bad++; $display("FAIL ign_prod got %h want 0f", host.product); end
    vec++; if (mosi_sh[17:10] !== 8'h53) begin bad++; $display("FAIL ign_mosi got %h want 53", mosi_sh[17:10]); end
    @(negedge clk);
    do_txn(4'h2, 4'h4, 8'h08, lat, csb, hib, p);
    vec++; if (p !== 8'h08) begin bad++; $display("FAIL ign_next_prod got %h want 08", p); end
    vec++; if (mosi_sh[17:10] !== 8'h42) begin bad++; $display("FAIL ign_next_mosi got %h want 42", mosi_sh[17:10]); end
    vec++; if (lat !== LAT) begin bad++; $display("FAIL ign_next_lat got %0d want %0d", lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    host.a = 4'h7; host.b = 4'h6; resp = 8'h2A;
    host.start = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    n = 1;
    while (host.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vec++; if (n !== LAT) begin bad++; $display("FAIL b2b_lat1 got %0d want %0d", n, LAT); end
    vec++; if (host.product !== 8'h2A) begin bad++; $display("FAIL b2b_prod1 got %h want 2a", host.product); end
    vec++; if (mosi_sh[17:10] !== 8'h67) begin bad++; $display("FAIL b2b_mosi1 got %h want 67", mosi_sh[17:10]); end
    vec++; if (CS !== 1'b1) begin bad++; $display("FAIL b2b_cs_gap got %b want 1", CS); end
    host.a = 4'h9; host.b = 4'hC; resp = 8'h6C;
    @(negedge clk);
    n = 1;
    vec++; if (host.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got %b want 1", host.busy); end
    while (host.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    host.start = 1'b0;
    vec++; if (n !== LAT) begin bad++; $display("FAIL b2b_lat2 got %0d want %0d", n, LAT); end
    vec++; if (host.product !== 8'h6C) begin bad++; $display("FAIL b2b_prod2 got %h want 6c", host.product); end
    vec++; if (mosi_sh[17:10] !== 8'hC9) begin bad++; $display("FAIL b2b_mosi2 got %h want c9", mosi_sh[17:10]); end
    @(negedge clk);
    vec++; if (host.busy !== 1'b0) begin bad++; $display("FAIL b2b_stop got %b want 0", host.busy); end
  endtask

  task automatic test_check();
    int lat, csb, hib;
    logic [7:0] p;
    logic want_err;
    do_txn(4'h2, 4'h7, 8'h0E, lat, csb, hib, p);
    vec++; if (p !== 8'h0E) begin bad++; $display("FAIL chk_prod_ok got %h want 0e", p); end
    vec++; if (host.err !== 1'b0) begin bad++; $display("FAIL chk_err_ok got %b want 0", host.err); end
    @(negedge clk);
    do_txn(4'h2, 4'h7, 8'h0F, lat, csb, hib, p);
`ifdef SPI_MULT_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    vec++; if (p !== 8'h0F) begin bad++; $display("FAIL chk_prod_bad got %h want 0f", p); end
    vec++; if (host.err !== want_err) begin bad++; $display("FAIL chk_err_bad got %b want %b", host.err, want_err); end
    repeat (3) @(negedge clk);
    vec++; if (host.err !== want_err) begin bad++; $display("FAIL chk_err_hold got %b want %b", host.err, want_err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    host.start = 1'b0;
    host.a = '0;
    host.b = '0;
    test_reset();
    test_basic();
    test_mid_reset();
    test_max();
    test_busy_ignore();
    test_back_to_back();
    test_check();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
